// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle SLL/SRL/SRA sequencer, STEP bits per cycle
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             amt_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] amt_reg,
    input  logic [AMT_W-1:0] amt_imm,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_BAD = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [AMT_W-1:0] start_amt;
    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] shifted;
    logic             unused_amt_hi;

    assign unused_amt_hi = ^amt_reg[WIDTH-1:AMT_W];
    assign start_amt     = amt_sel ? amt_reg[AMT_W-1:0] : amt_imm;

    // k <= rem < 2^AMT_W, so truncating STEP is safe whenever it is selected
    assign k = (int'(rem_q) < STEP) ? rem_q : AMT_W'(STEP);

    always_comb begin
        shifted = acc_q;
        case (op_q)
            OP_SLL:  shifted = acc_q << k;
            OP_SRL:  shifted = acc_q >> k;
            default: shifted = (acc_q >> k) |
                               (sign_q ? ~({WIDTH{1'b1}} >> k) : {WIDTH{1'b0}});
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d   = op;
                    acc_d  = data_in;
                    rem_d  = start_amt;
                    sign_d = data_in[WIDTH-1];
                    if (op == OP_BAD || start_amt == '0) begin
                        state_d  = S_DONE;
                        result_d = data_in;
                        err_d    = (op == OP_BAD);
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = shifted;
                rem_d = rem_q - k;
                if (rem_q == k) begin
                    state_d  = S_DONE;
                    result_d = shifted;
                    err_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign err    = done & err_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl (STEP=1 and STEP=4 instances)
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, amt_sel;
    logic [1:0]  op;
    logic [31:0] data_in, amt_reg;
    logic [4:0]  amt_imm;
    logic        busy, done, err;
    logic [31:0] result;

    logic        start4, amt_sel4;
    logic [1:0]  op4;
    logic [31:0] data_in4, amt_reg4;
    logic [4:0]  amt_imm4;
    logic        busy4, done4, err4;
    logic [31:0] result4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    logic [31:0] last_res = '0;

    shift_seq_ctrl #(.WIDTH(32), .AMT_W(5), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt_sel(amt_sel),
        .data_in(data_in), .amt_reg(amt_reg), .amt_imm(amt_imm),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    shift_seq_ctrl #(.WIDTH(32), .AMT_W(5), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .amt_sel(amt_sel4),
        .data_in(data_in4), .amt_reg(amt_reg4), .amt_imm(amt_imm4),
        .busy(busy4), .done(done4), .err(err4), .result(result4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain language-level shifts on the full amount
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] d, input int amt);
        case (o)
            2'd0:    return d << amt;
            2'd1:    return d >> amt;
            2'd2:    return 32'($signed(d) >>> amt);
            default: return d;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input int amt, input int step);
        if (o == 2'd3 || amt == 0) return 1;
        return (amt + step - 1) / step + 1;
    endfunction

    // Monitor: checks every cycle away from the clock edge
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res = '0;
        end else begin
            if (busy && done) check("busy_and_done", 1, 0);
            if (err && !done) check("err_without_done", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", 64'(cyc), 64'(sb[0].cyc));
                    check("result", 64'(result), 64'(sb[0].res));
                    check("err", 64'(err), 64'(sb[0].err));
                    void'(sb.pop_front());
                end
                last_res = result;
            end else begin
                check("result_hold", 64'(result), 64'(last_res));
                if (sb.size() != 0 && cyc > sb[0].cyc) begin
                    check("done_timeout", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] d,
                         input logic [31:0] r, input logic [4:0] imm);
        int   g;
        int   amt;
        exp_t e;
        g = 0;
        while (busy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy) begin
            check("issue_wait_busy", 1, 0);
            return;
        end
        op = o; amt_sel = s; data_in = d; amt_reg = r; amt_imm = imm; start = 1'b1;
        amt   = s ? int'(r[4:0]) : int'(imm);
        e.res = ref_res(o, d, amt);
        e.err = (o == 2'd3);
        e.cyc = cyc + ref_lat(o, amt, 1);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); data_in = $urandom; amt_reg = $urandom; amt_imm = 5'($urandom);
    endtask

    task automatic ignored_pulse();
        if (busy) begin
            start = 1'b1; op = 2'($urandom); data_in = $urandom; amt_imm = 5'($urandom);
            amt_sel = 1'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic run4(input logic [1:0] o, input logic [31:0] d, input int amt);
        int n;
        n = 0;
        while (busy4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        op4 = o; data_in4 = d; amt_sel4 = 1'b0; amt_imm4 = 5'(amt); amt_reg4 = $urandom;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; data_in4 = $urandom;
        n = 1;
        while (!done4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("s4_latency", 64'(n), 64'(ref_lat(o, amt, 4)));
        check("s4_result", 64'(result4), 64'(ref_res(o, d, amt)));
        check("s4_err", 64'(err4), 64'(o == 2'd3));
    endtask

    initial begin
        int g;
        rst_n = 1'b0; start = 1'b0; op = '0; amt_sel = 1'b0; data_in = '0; amt_reg = '0; amt_imm = '0;
        start4 = 1'b0; op4 = '0; amt_sel4 = 1'b0; data_in4 = '0; amt_reg4 = '0; amt_imm4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_result", 64'(result), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'd0, 1'b0, 32'h0000_0001, 32'h0, 5'd31);
        issue(2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0);
        issue(2'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0);
        issue(2'd1, 1'b0, 32'h1234_5678, 32'h0, 5'd0);
        issue(2'd3, 1'b0, 32'h1234_5678, 32'h0, 5'd9);

        issue(2'd0, 1'b0, 32'h0000_0003, 32'h0, 5'd10);
        repeat (2) @(posedge clk);
        #1;
        ignored_pulse();
        g = 0;
        while (busy && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("b2b_in_done", 64'(done), 1);
        issue(2'd2, 1'b0, 32'hF000_0000, 32'h0, 5'd3);

        issue(2'd0, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd20);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_busy", 64'(busy), 0);
        check("arst_done", 64'(done), 0);
        check("arst_result", 64'(result), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(2'd1, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd5);

        for (int i = 0; i < 150; i++) begin
            logic [1:0] o;
            o = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(o, 1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
            if ($urandom_range(0, 4) == 0) ignored_pulse();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        run4(2'd0, 32'h0000_000F, 7);
        for (int i = 0; i < 12; i++) begin
            run4(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 31));
        end

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("sb_drained", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
